fixed_point_addsub_arbiter: RTL and testbench

- Shares one signed fixed-point add/sub datapath between NREQ requesters.
- Each requester presents operands A and B, a subtract flag and a valid bit. The block grants one requester at a time in round-robin order, then computes a saturated A+B or A−B.
- The result is returned on a single valid/ready response channel, tagged with the requester ID.
- Sits between the filter-stage sequencers and the shared add/sub arithmetic resource.

---
 rtl/fixed_point_addsub_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fixed_point_addsub_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// fixed_point_addsub_arbiter: round-robin shared saturating signed add/sub unit
// Rev 1.0
// ============================================================================
module fixed_point_addsub_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ*DW-1:0] i_req_a,
  input  logic [NREQ*DW-1:0] i_req_b,
  input  logic [NREQ-1:0]    i_req_sub,
  output logic [NREQ-1:0]    o_req_ready,
  output logic               o_res_valid,
  output logic [DW-1:0]      o_res_data,
  output logic [IDW-1:0]     o_res_id,
  output logic               o_res_sat,
  input  logic               i_res_ready,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic            sub_q, sub_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            res_valid_q, res_valid_d;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic            res_sat_q, res_sat_d;

  logic [IDW-1:0]  cand_idx [NREQ];
  logic            grant_found;
  logic [IDW-1:0]  grant_idx;

  logic [DW:0]     a_ext;
  logic [DW:0]     b_ext;
  logic [DW:0]     sum_ext;
  logic            ovf;
  logic [DW-1:0]   sat_val;

  // Candidate i is the requester i positions above the pointer, wrapped at NREQ.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDW:0] raw;
    assign raw = {1'b0, ptr_q} + (IDW+1)'(gi);
    assign cand_idx[gi] = (raw >= (IDW+1)'(NREQ)) ? IDW'(raw - (IDW+1)'(NREQ))
                                                   : raw[IDW-1:0];
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && i_req_valid[cand_idx[i]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[i];
      end
    end
  end

  always_comb begin
    a_ext   = {a_q[DW-1], a_q};
    b_ext   = {b_q[DW-1], b_q};
    sum_ext = sub_q ? (a_ext - b_ext) : (a_ext + b_ext);
    if (sub_q) begin
      ovf = (a_q[DW-1] != b_q[DW-1]) && (sum_ext[DW-1] != a_q[DW-1]);
    end else begin
      ovf = (a_q[DW-1] == b_q[DW-1]) && (sum_ext[DW-1] != a_q[DW-1]);
    end
    // The extra top bit carries the true sign, which picks the clamp direction.
    sat_val = sum_ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_sat_d   = res_sat_q;
    o_req_ready = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          o_req_ready[grant_idx] = i_reset_n;
          a_d     = i_req_a[int'(grant_idx)*DW +: DW];
          b_d     = i_req_b[int'(grant_idx)*DW +: DW];
          sub_d   = i_req_sub[grant_idx];
          id_d    = grant_idx;
          ptr_d   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_data_d  = ovf ? sat_val : sum_ext[DW-1:0];
        res_id_d    = id_q;
        res_sat_d   = ovf;
        res_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (i_res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_sat_q   <= res_sat_d;
    end
  end

  assign o_res_valid = res_valid_q;
  assign o_res_data  = res_data_q;
  assign o_res_id    = res_id_q;
  assign o_res_sat   = res_sat_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fixed_point_addsub_arbiter: directed self-checking bench for the arbiter
// Rev 1.0
// ============================================================================
module tb_fixed_point_addsub_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_sub;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid;
  logic [DW-1:0]      res_data;
  logic [IDW-1:0]     res_id;
  logic               res_sat;
  logic               res_ready;
  logic               busy;

  int n_checks;
  int n_errors;

  fixed_point_addsub_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_sub   (req_sub),
    .o_req_ready (req_ready),
    .o_res_valid (res_valid),
    .o_res_data  (res_data),
    .o_res_id    (res_id),
    .o_res_sat   (res_sat),
    .i_res_ready (res_ready),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic s);
    req_a[k*DW +: DW] = a;
    req_b[k*DW +: DW] = b;
    req_sub[k]        = s;
  endtask

  // Starts at a negedge in IDLE with no pointer dependence (single requester).
  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] exp_d, input logic exp_s);
    set_req(k, a, b, s);
    req_valid    = '0;
    req_valid[k] = 1'b1;
    #1;
    check_eq("grant_onehot", 32'(req_ready), 32'(1) << k);
    check_eq("idle_busy", 32'(busy), 0);
    @(negedge clk);
    req_valid = '0;
    check_eq("exec_ready", 32'(req_ready), 0);
    check_eq("exec_busy", 32'(busy), 1);
    check_eq("exec_res_valid", 32'(res_valid), 0);
    @(negedge clk);
    check_eq("resp_valid", 32'(res_valid), 1);
    check_eq("resp_data", 32'(res_data), 32'(exp_d));
    check_eq("resp_id", 32'(res_id), k);
    check_eq("resp_sat", 32'(res_sat), 32'(exp_s));
    @(negedge clk);
    check_eq("post_valid", 32'(res_valid), 0);
    check_eq("post_data_hold", 32'(res_data), 32'(exp_d));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 0);
    check_eq("rst_valid", 32'(res_valid), 0);
    check_eq("rst_data", 32'(res_data), 0);
    check_eq("rst_id", 32'(res_id), 0);
    check_eq("rst_sat", 32'(res_sat), 0);
    check_eq("rst_busy", 32'(busy), 0);
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Plain add, then saturation boundaries in both directions.
    run_op(0, 8'h10, 8'h22, 1'b0, 8'h32, 1'b0);
    run_op(0, 8'hF0, 8'h05, 1'b0, 8'hF5, 1'b0);
    run_op(1, 8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b1);
    run_op(2, 8'h80, 8'hFF, 1'b0, 8'h80, 1'b1);
    run_op(1, 8'h70, 8'h20, 1'b0, 8'h7F, 1'b1);
    run_op(2, 8'h80, 8'h01, 1'b1, 8'h80, 1'b1);
    run_op(3, 8'h80, 8'h80, 1'b1, 8'h00, 1'b0);

    // Pointer is now 0: all four request continuously.
    for (int k = 0; k < NREQ; k++) set_req(k, 8'(k), 8'h10, 1'b0);
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      #1;
      check_eq("rr_grant", 32'(req_ready), 32'(1) << (n % NREQ));
      @(negedge clk);
      check_eq("rr_exec_ready", 32'(req_ready), 0);
      @(negedge clk);
      check_eq("rr_resp_valid", 32'(res_valid), 1);
      check_eq("rr_resp_id", 32'(res_id), n % NREQ);
      check_eq("rr_resp_data", 32'(res_data), 32'h10 + (n % NREQ));
      check_eq("rr_resp_ready", 32'(req_ready), 0);
      if (n == 4) req_valid = '0;
      @(negedge clk);
    end
    #1;
    check_eq("idle_no_req", 32'(req_ready), 0);
    check_eq("idle_no_busy", 32'(busy), 0);

    // Pointer is 1 with only requesters 3 and 0 valid.
    req_valid = 4'b1001;
    #1;
    check_eq("skip_grant3", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    check_eq("skip_id3", 32'(res_id), 3);
    check_eq("skip_data3", 32'(res_data), 32'h13);
    @(negedge clk);
    #1;
    check_eq("skip_grant0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check_eq("skip_id0", 32'(res_id), 0);
    @(negedge clk);

    // Pointer should be back at 1: 0 and 1 valid picks 1. Then backpressure.
    set_req(1, 8'h05, 8'h03, 1'b1);
    req_valid = 4'b0011;
    #1;
    check_eq("ptr_end_grant1", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '1;
    res_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check_eq("bp_valid", 32'(res_valid), 1);
      check_eq("bp_data", 32'(res_data), 32'h02);
      check_eq("bp_id", 32'(res_id), 1);
      check_eq("bp_no_ready", 32'(req_ready), 0);
      if (i < 5) @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("bp_done_valid", 32'(res_valid), 0);
    check_eq("bp_next_grant", 32'(req_ready), 32'h4);

    // Abort in EXEC with asynchronous reset.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", 32'(res_valid), 0);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_ready", 32'(req_ready), 0);
    check_eq("abort_data", 32'(res_data), 0);
    check_eq("abort_id", 32'(res_id), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("release_valid", 32'(res_valid), 0);
    check_eq("release_grant0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    check_eq("release_exec_valid", 32'(res_valid), 0);
    @(negedge clk);
    check_eq("release_resp_id", 32'(res_id), 0);
    check_eq("release_resp_data", 32'(res_data), 32'h10);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
